isp_capture_sequencer: RTL and testbench
========================================

# isp_capture_sequencer

Four-shot photo-booth capture controller for the four-quadrant ISP. After a start press it counts down a fixed number of seconds, measured in camera frames. It then opens exactly one full frame of write enable into the frame buffer of the current slot, and repeats for slots 0–3. It also drives the four per-quadrant effect-select bits that feed the ISP output muxes, and a countdown digit for the on-screen overlay.

## Interface
Parameters:
- FRAMES_PER_SEC, default 60: frame_start pulses per countdown second (≥2).
- COUNT_SEC, default 3: countdown length per slot in seconds (1–9).

Ports:
- clk  in  1  pixel/system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_start  in  1  one-cycle debounced pulse; starts a session.
- btn_cancel  in  1  one-cycle debounced pulse; aborts a session.
- frame_start  in  1  one-cycle pulse, one clk before the first pixel of each camera frame.
- mode_sw  in  4  requested effect per slot (bit i → slot i).
- fb_we  out  4  one-hot frame-buffer write enable (bit i → buffer i).
- image_mode  out  4  effect select to the ISP muxes (bit i → quadrant i+1).
- count_digit  out  4  seconds remaining in COUNT; 0 otherwise.
- slot_idx  out  2  slot currently being counted or captured.
- busy  out  1  high in COUNT or CAPTURE.
- done  out  1  high in DONE.

## Operation
- States: IDLE, COUNT, CAPTURE, DONE. All outputs are registered.
- Counters:
  - sec_cnt: 4 bits.
  - frame_cnt: $clog2(FRAMES_PER_SEC) bits.
  - slot_idx: 2 bits.
- IDLE → COUNT on btn_start. Sets slot_idx=0, sec_cnt=COUNT_SEC, frame_cnt=0. Latches mode_sw (see Configuration).
- COUNT: each frame_start increments frame_cnt.
  - When frame_cnt==FRAMES_PER_SEC-1 and frame_start: frame_cnt wraps to 0 and sec_cnt decrements.
  - If sec_cnt==1 at that wrap: go to CAPTURE and set fb_we=onehot(slot_idx) on the same edge. sec_cnt becomes 0.
- CAPTURE: fb_we is held for one whole frame. On the next frame_start, fb_we is cleared. That pulse is not counted for the next countdown. Then:
  - If slot_idx<3: increment slot_idx, reload sec_cnt=COUNT_SEC and frame_cnt=0, go to COUNT.
  - If slot_idx==3: go to DONE. slot_idx stays 3.
- DONE: hold. btn_start restarts at slot 0 exactly as from IDLE. btn_cancel → IDLE.
- btn_cancel in COUNT or CAPTURE → IDLE on the next edge. fb_we is cleared immediately and image_mode is cleared. Buffers keep any partially written data.
- btn_start in COUNT or CAPTURE is ignored.
- Cancel and start in the same cycle: cancel wins in every state. In IDLE, a simultaneous pair leaves the block in IDLE.
- frame_start in IDLE or DONE is ignored.
- count_digit = sec_cnt in COUNT, 0 in all other states.
- fb_we is never multi-hot; at most one bit is high.

## Timing
- Reset values: state=IDLE, fb_we=0, image_mode=0, count_digit=0, slot_idx=0, busy=0, done=0.
- fb_we rises the cycle after the final countdown frame_start. It falls the cycle after the next frame_start, so it covers exactly one frame.
- busy and done change the cycle after the triggering pulse.
- Per-slot cost: FRAMES_PER_SEC×COUNT_SEC frame_starts of countdown plus 1 frame_start to close CAPTURE.
- Session length from btn_start to done: 4×(FRAMES_PER_SEC×COUNT_SEC+1) frame_starts.
- Reset asserted mid-session: every output returns to its reset value immediately (asynchronously); there is no resumption.

## Configuration
- Macro: ISP_SEQ_AUTO_EFFECT_EN.
- Defined:
  - image_mode clears on session start.
  - Bit i sets on the edge that closes CAPTURE of slot i, i.e. the effect turns on once slot i is captured.
  - mode_sw is a 1-bit mask per slot: a bit of 0 keeps that slot's image_mode at 0.
- Undefined: image_mode is loaded with mode_sw on the start edge and held until cancel or the next start.

## Test plan
- FRAMES_PER_SEC=2, COUNT_SEC=2, btn_start then frame_start every 10 cycles:
  - count_digit reads 2, 2, 1, 1.
  - fb_we=0001 for exactly one frame, starting the cycle after the 4th frame_start.
  - fb_we=0010 follows after the 9th frame_start.
  - done=1 the cycle after the 20th frame_start, with fb_we never multi-hot.
- btn_cancel during slot 2 CAPTURE → next cycle state=IDLE, fb_we=0, image_mode=0, busy=0.
- btn_start and btn_cancel in the same cycle, in IDLE and in COUNT → IDLE in both cases, no counting.
- Async reset pulse mid-COUNT, between clock edges → all outputs are 0 before the next clk edge.
- btn_start pulses during COUNT → ignored, sequence timing unchanged. btn_start in DONE → restarts at slot 0.
- mode_sw=1010:
  - With the macro defined, image_mode goes 0000→0000→0010→0010→1010 as slots 0..3 close.
  - Without the macro, image_mode=1010 from the cycle after btn_start.

Source files
------------

// File: rtl/isp_capture_sequencer_if.sv
// Control/status bundle for the four-shot capture sequencer.
// The master side (booth controller / testbench) drives the buttons, the frame
// strobe and the effect request; the slave side (the sequencer) drives the
// frame-buffer enables, ISP effect selects and the overlay status.
interface isp_capture_sequencer_if;
  logic       btn_start;
  logic       btn_cancel;
  logic       frame_start;
  logic [3:0] mode_sw;
  logic [3:0] fb_we;
  logic [3:0] image_mode;
  logic [3:0] count_digit;
  logic [1:0] slot_idx;
  logic       busy;
  logic       done;

  modport master (
    output btn_start, btn_cancel, frame_start, mode_sw,
    input  fb_we, image_mode, count_digit, slot_idx, busy, done
  );

  modport slave (
    input  btn_start, btn_cancel, frame_start, mode_sw,
    output fb_we, image_mode, count_digit, slot_idx, busy, done
  );
endinterface

// File: rtl/isp_capture_sequencer.sv
// Four-shot photo-booth capture sequencer.
// After btn_start, each of slots 0..3 gets a COUNT_SEC-second countdown
// (measured in FRAMES_PER_SEC frame_start pulses per second) followed by
// exactly one frame of one-hot frame-buffer write enable.
// Optional feature macro ISP_SEQ_AUTO_EFFECT_EN: when defined, image_mode
// starts at zero each session and bit i turns on (masked by the latched
// mode_sw bit i) as slot i's capture closes. When undefined, image_mode is
// loaded from mode_sw on the start edge and held.
module isp_capture_sequencer #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNT_SEC      = 3
) (
  input logic                    clk,
  input logic                    reset,
  isp_capture_sequencer_if.slave bus
);

  localparam int unsigned FW = (FRAMES_PER_SEC > 2) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [3:0]    SEC_LOAD   = 4'(COUNT_SEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sec_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [1:0]    r_slot_idx;
  logic [3:0]    r_fb_we;
  logic [3:0]    r_image_mode;
  logic [3:0]    r_count_digit;
  logic          r_busy;
  logic          r_done;

  state_t        w_nxt_state;
  logic [3:0]    w_nxt_sec_cnt;
  logic [FW-1:0] w_nxt_frame_cnt;
  logic [1:0]    w_nxt_slot_idx;
  logic [3:0]    w_nxt_fb_we;
  logic [3:0]    w_nxt_image_mode;
  logic [3:0]    w_nxt_count_digit;
  logic          w_nxt_busy;
  logic          w_nxt_done;
  logic          w_launch;
  logic          w_abort;

  logic          w_start;
  logic          w_cancel;
  logic          w_frame;
  logic [3:0]    w_mode_sw;
  logic [3:0]    w_slot_onehot;

`ifdef ISP_SEQ_AUTO_EFFECT_EN
  logic [3:0]    r_mode_mask;
  logic [3:0]    w_nxt_mode_mask;
`endif

  assign w_start       = bus.btn_start;
  assign w_cancel      = bus.btn_cancel;
  assign w_frame       = bus.frame_start;
  assign w_mode_sw     = bus.mode_sw;
  assign w_slot_onehot = 4'b0001 << r_slot_idx;

  // Next-state and next-output decode; every output is the registered copy
  // of its next value so all outputs change together on the clock edge.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_sec_cnt    = r_sec_cnt;
    w_nxt_frame_cnt  = r_frame_cnt;
    w_nxt_slot_idx   = r_slot_idx;
    w_nxt_fb_we      = r_fb_we;
    w_nxt_image_mode = r_image_mode;
    w_launch         = 1'b0;
    w_abort          = 1'b0;
`ifdef ISP_SEQ_AUTO_EFFECT_EN
    w_nxt_mode_mask  = r_mode_mask;
`endif

    case (r_state)
      S_IDLE: begin
        if (!w_cancel && w_start) w_launch = 1'b1;
      end

      S_COUNT: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_frame) begin
          if (r_frame_cnt == FRAME_LAST) begin
            w_nxt_frame_cnt = '0;
            w_nxt_sec_cnt   = r_sec_cnt - 4'd1;
            if (r_sec_cnt == 4'd1) begin
              w_nxt_state = S_CAPTURE;
              w_nxt_fb_we = w_slot_onehot;
            end
          end else begin
            w_nxt_frame_cnt = r_frame_cnt + FW'(1);
          end
        end
      end

      S_CAPTURE: begin
        if (w_cancel) begin
          w_abort = 1'b1;
        end else if (w_frame) begin
          // The closing pulse is consumed here and never reaches the next
          // countdown, which restarts from frame_cnt=0.
          w_nxt_fb_we = '0;
`ifdef ISP_SEQ_AUTO_EFFECT_EN
          w_nxt_image_mode = r_image_mode | (r_mode_mask & w_slot_onehot);
`endif
          if (r_slot_idx != 2'd3) begin
            w_nxt_slot_idx  = r_slot_idx + 2'd1;
            w_nxt_sec_cnt   = SEC_LOAD;
            w_nxt_frame_cnt = '0;
            w_nxt_state     = S_COUNT;
          end else begin
            w_nxt_state = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (w_cancel) w_abort = 1'b1;
        else if (w_start) w_launch = 1'b1;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_nxt_state      = S_IDLE;
      w_nxt_fb_we      = '0;
      w_nxt_image_mode = '0;
      w_nxt_slot_idx   = '0;
      w_nxt_sec_cnt    = '0;
      w_nxt_frame_cnt  = '0;
    end

    if (w_launch) begin
      w_nxt_state     = S_COUNT;
      w_nxt_slot_idx  = '0;
      w_nxt_sec_cnt   = SEC_LOAD;
      w_nxt_frame_cnt = '0;
      w_nxt_fb_we     = '0;
`ifdef ISP_SEQ_AUTO_EFFECT_EN
      w_nxt_image_mode = '0;
      w_nxt_mode_mask  = w_mode_sw;
`else
      w_nxt_image_mode = w_mode_sw;
`endif
    end

    w_nxt_count_digit = (w_nxt_state == S_COUNT) ? w_nxt_sec_cnt : '0;
    w_nxt_busy        = (w_nxt_state == S_COUNT) || (w_nxt_state == S_CAPTURE);
    w_nxt_done        = (w_nxt_state == S_DONE);
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sec_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_slot_idx    <= '0;
      r_fb_we       <= '0;
      r_image_mode  <= '0;
      r_count_digit <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_sec_cnt     <= w_nxt_sec_cnt;
      r_frame_cnt   <= w_nxt_frame_cnt;
      r_slot_idx    <= w_nxt_slot_idx;
      r_fb_we       <= w_nxt_fb_we;
      r_image_mode  <= w_nxt_image_mode;
      r_count_digit <= w_nxt_count_digit;
      r_busy        <= w_nxt_busy;
      r_done        <= w_nxt_done;
    end
  end

`ifdef ISP_SEQ_AUTO_EFFECT_EN
  // Per-slot effect mask captured at session start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mode_mask <= '0;
    else       r_mode_mask <= w_nxt_mode_mask;
  end
`endif

  assign bus.fb_we       = r_fb_we;
  assign bus.image_mode  = r_image_mode;
  assign bus.count_digit = r_count_digit;
  assign bus.slot_idx    = r_slot_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_isp_capture_sequencer.sv
// Directed bench for isp_capture_sequencer with FRAMES_PER_SEC=2, COUNT_SEC=2.
// Observed outputs are packed as {fb_we, image_mode, count_digit, slot_idx, busy, done}.
module tb_isp_capture_sequencer;
  localparam int FPS = 2;
  localparam int CS  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  isp_capture_sequencer_if bus ();

  isp_capture_sequencer #(
    .FRAMES_PER_SEC(FPS),
    .COUNT_SEC     (CS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_multihot = 0;

  typedef struct packed {
    logic       start;
    logic       cancel;
    logic       fs;
    logic [3:0] fb;
    logic [3:0] im_def;
    logic [3:0] im_auto;
    logic [3:0] dig;
    logic [1:0] slot;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vt [11];

  always @(negedge clk) if ($countones(bus.fb_we) > 1) n_multihot++;

  function automatic logic [15:0] pk(input logic [3:0] fb, input logic [3:0] im,
                                     input logic [3:0] dig, input logic [1:0] slot,
                                     input logic busy, input logic done);
    return {fb, im, dig, slot, busy, done};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.fb_we, bus.image_mode, bus.count_digit, bus.slot_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [3:0] pick_im(input logic [3:0] im_def, input logic [3:0] im_auto);
`ifdef ISP_SEQ_AUTO_EFFECT_EN
    return im_auto;
`else
    return im_def;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Idle-state check ignoring slot_idx, whose value in IDLE is not defined.
  task automatic chk_idle(input string name);
    logic [15:0] a;
    a = obs();
    a[3:2] = 2'b00;
    chk(name, a, 16'h0000);
  endtask

  task automatic step(input logic s, input logic c, input logic f);
    @(negedge clk);
    bus.btn_start   = s;
    bus.btn_cancel  = c;
    bus.frame_start = f;
    @(posedge clk);
    #1;
    bus.btn_start   = 1'b0;
    bus.btn_cancel  = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] mode;
    logic [3:0] exp_auto;
    logic [3:0] fb;
    logic [3:0] dig;
    logic [1:0] slot;
    logic       busy;
    logic       done;
    int         q;

    mode = 4'b1010;
    bus.btn_start   = 1'b0;
    bus.btn_cancel  = 1'b0;
    bus.frame_start = 1'b0;
    bus.mode_sw     = mode;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), 16'h0000);
    reset = 1'b0;
    idle(2);

    //         st   cn   fs   fb       im_def   im_auto  dig  slot busy done
    vt[0]  = '{1'b1,1'b0,1'b0,4'b0000,4'b1010,4'b0000,4'd2,2'd0,1'b1,1'b0};
    vt[1]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd2,2'd0,1'b1,1'b0};
    vt[2]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd1,2'd0,1'b1,1'b0};
    vt[3]  = '{1'b1,1'b0,1'b0,4'b0000,4'b1010,4'b0000,4'd1,2'd0,1'b1,1'b0};
    vt[4]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd1,2'd0,1'b1,1'b0};
    vt[5]  = '{1'b0,1'b0,1'b1,4'b0001,4'b1010,4'b0000,4'd0,2'd0,1'b1,1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd2,2'd1,1'b1,1'b0};
    vt[7]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd2,2'd1,1'b1,1'b0};
    vt[8]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd1,2'd1,1'b1,1'b0};
    vt[9]  = '{1'b0,1'b0,1'b1,4'b0000,4'b1010,4'b0000,4'd1,2'd1,1'b1,1'b0};
    vt[10] = '{1'b0,1'b0,1'b1,4'b0010,4'b1010,4'b0000,4'd0,2'd1,1'b1,1'b0};

    for (int i = 0; i < 11; i++) begin
      step(vt[i].start, vt[i].cancel, vt[i].fs);
      chk($sformatf("vec%0d", i), obs(),
          pk(vt[i].fb, pick_im(vt[i].im_def, vt[i].im_auto), vt[i].dig,
             vt[i].slot, vt[i].busy, vt[i].done));
      idle(8);
    end

    // Frame_starts 10..20 of the session, expected values from a slot model.
    exp_auto = 4'b0000;
    for (int k = 10; k <= 20; k++) begin
      q = k % 5;
      fb = 4'b0000; busy = 1'b1; done = 1'b0;
      if (q == 0) begin
        if (mode[k/5 - 1]) exp_auto[k/5 - 1] = 1'b1;
        if (k == 20) begin
          slot = 2'd3; dig = 4'd0; busy = 1'b0; done = 1'b1;
        end else begin
          slot = 2'(k/5); dig = 4'd2;
        end
      end else begin
        slot = 2'((k-1)/5);
        dig  = (q == 1) ? 4'd2 : (q == 4) ? 4'd0 : 4'd1;
        if (q == 4) fb = 4'b0001 << slot;
      end
      step(1'b0, 1'b0, 1'b1);
      chk($sformatf("fs%0d", k), obs(), pk(fb, pick_im(mode, exp_auto), dig, slot, busy, done));
      idle(8);
    end

    // frame_start in DONE is ignored.
    step(1'b0, 1'b0, 1'b1);
    chk("done_hold", obs(), pk(4'b0000, pick_im(mode, exp_auto), 4'd0, 2'd3, 1'b0, 1'b1));

    // btn_start in DONE restarts at slot 0.
    step(1'b1, 1'b0, 1'b0);
    chk("restart", obs(), pk(4'b0000, pick_im(mode, 4'b0000), 4'd2, 2'd0, 1'b1, 1'b0));

    // Advance to slot 2 CAPTURE, then cancel.
    repeat (14) step(1'b0, 1'b0, 1'b1);
    chk("slot2_cap", obs(), pk(4'b0100, pick_im(mode, 4'b0010), 4'd0, 2'd2, 1'b1, 1'b0));
    step(1'b0, 1'b1, 1'b0);
    chk_idle("cancel_cap");
    step(1'b0, 1'b0, 1'b1);
    chk_idle("idle_fs_ignored");

    // Simultaneous start+cancel in IDLE stays idle.
    step(1'b1, 1'b1, 1'b0);
    chk_idle("sc_idle");
    step(1'b0, 1'b0, 1'b1);
    chk_idle("sc_idle_nocount");

    // Simultaneous start+cancel in COUNT aborts.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("count_again", obs(), pk(4'b0000, pick_im(mode, 4'b0000), 4'd2, 2'd0, 1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b0);
    chk_idle("sc_count");
    step(1'b0, 1'b0, 1'b1);
    chk_idle("sc_count_nocount");

    // Asynchronous reset between edges during COUNT.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("pre_reset", obs(), pk(4'b0000, pick_im(mode, 4'b0000), 4'd1, 2'd0, 1'b1, 1'b0));
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), 16'h0000);
    #1 reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    chk("no_resume", obs(), 16'h0000);

    chk("never_multihot", 16'(n_multihot), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
